// File: rtl/qucs_serial_pkg.sv
// Shared types and constants for the qucs serial stimulus link.
// Optional feature macro: QUCS_SERIAL_TX_PARITY_EN (adds an even-parity bit).
package qucs_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Line level while no frame is on the wire.
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef QUCS_SERIAL_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  // The receiver model uses the same figure to size its frame timeout.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int stop_bits, input int parity_bits);
    return clks_per_bit * (1 + data_w + parity_bits + stop_bits);
  endfunction

endpackage

// File: rtl/qucs_serial_tx_if.sv
// Parallel word handshake into the qucs serial transmitter.
// master drives words, slave (the transmitter) drives in_ready.
interface qucs_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/qucs_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every bit with bit_tick_o. clear_i holds the count at zero.
module qucs_baud_gen #(
  parameter  int CLKS_PER_BIT = 16,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             bit_tick_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == LAST_CNT);
  assign cnt_o      = cnt_q;

  // Next count: held at zero on clear, wraps at each bit boundary.
  always_comb begin
    if (clear_i || bit_tick_o) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/qucs_serial_tx.sv
// UART-style serializer: start bit, LSB-first data, optional parity, stop bits.
// Optional feature macro: QUCS_SERIAL_TX_PARITY_EN (even parity after DATA).
// All outputs come straight from flops; tx never sees in_* combinationally.
module qucs_serial_tx
  import qucs_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  qucs_serial_tx_if.slave   in_if,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("qucs_serial_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("qucs_serial_tx: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
    $error("qucs_serial_tx: DATA_W must be in 5..16");
  end

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic              bit_tick;
  logic              accept;

  assign accept = in_if.in_valid && ready_q;

  // The bit timer restarts from zero for every frame because it is held
  // clear for as long as the FSM sits in IDLE, including the accept cycle.
  qucs_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (state_q == IDLE),
    .cnt_o      (bit_cnt),
    .bit_tick_o (bit_tick)
  );

`ifdef QUCS_SERIAL_TX_PARITY_EN
  logic parity_q;

  // Even parity of the word, captured alongside the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_q <= 1'b0;
    else if (accept) parity_q <= ^in_if.in_data;
  end
`endif

  // State register plus the datapath it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: shreg and idx are reset as well, so a reset mid-frame leaves no
    // stale payload or bit position behind for the next frame.
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: advance one bit per bit_tick.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a hold latch.
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept) begin
          shreg_d = in_if.in_data;
          state_d = START;
        end
      end
      START: if (bit_tick) state_d = DATA;
      DATA: if (bit_tick) begin
        shreg_d = shreg_q >> 1;
        if (idx_q == LAST_DATA_IDX) begin
          idx_d = '0;
`ifdef QUCS_SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef QUCS_SERIAL_TX_PARITY_EN
      PARITY: if (bit_tick) state_d = STOP;
`endif
      STOP: if (bit_tick) begin
        if (idx_q == LAST_STOP_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe. done is set one cycle early, from the
  // second-to-last cycle of the final stop bit, so it lands on the last one.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_q == STOP) && (idx_q == LAST_STOP_IDX) &&
              (bit_cnt == PRE_LAST_CNT);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef QUCS_SERIAL_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  // Output registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign tx             = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign in_if.in_ready = ready_q;

endmodule

// File: tb/tb_qucs_serial_tx.sv
// Self-checking bench for qucs_serial_tx: scoreboard of accepted words,
// per-cycle frame monitor, plus a DATA_W=16 / CLKS_PER_BIT=2 limits instance.
module tb_qucs_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef QUCS_SERIAL_TX_PARITY_EN
  localparam int P  = 1;
  localparam int SB = 2;
`else
  localparam int P  = 0;
  localparam int SB = 1;
`endif
  localparam int L     = CPB * (1 + DW + P + SB);
  localparam int DW16  = 16;
  localparam int CPB16 = 2;
  localparam int L16   = CPB16 * (1 + DW16 + P + 1);

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tx, busy, done;
  logic tx16, busy16, done16;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   edges_since_rst;
  exp_t sb[$];
  bit   active = 1'b0;
  int   last_acc;

  qucs_serial_tx_if #(.DATA_W(DW))   bus ();
  qucs_serial_tx_if #(.DATA_W(DW16)) bus16 ();

  qucs_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus), .tx(tx), .busy(busy), .done(done)
  );

  qucs_serial_tx #(.DATA_W(DW16), .CLKS_PER_BIT(CPB16), .STOP_BITS(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_if(bus16), .tx(tx16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   edges_since_rst <= 0;
    else if (edges_since_rst < 2) edges_since_rst <= edges_since_rst + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line level in frame cycle k (1-based) of word w.
  function automatic logic exp_bit(input logic [15:0] w, input int dw, input int cpb, input int k);
    int b;
    b = (k - 1) / cpb;
    if (b == 0)                  return 1'b0;
    if (b <= dw)                 return w[b-1];
    if (P == 1 && b == dw + 1)   return ^w;
    return 1'b1;
  endfunction

  // Frame monitor for the main instance, sampling on the falling edge.
  initial begin
    exp_t cur;
    int   k;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        sb.delete();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", bus.in_ready, 0);
      end else begin
        if (!active && sb.size() > 0 && cyc == sb[0].acc + 1) begin
          cur    = sb.pop_front();
          active = 1'b1;
          k      = 0;
        end
        if (active) begin
          k++;
          check("frame_tx", tx, 32'(exp_bit(16'(cur.data), DW, CPB, k)));
          check("frame_busy", busy, 1);
          check("frame_done", done, 32'(k == L));
          check("frame_ready", bus.in_ready, 0);
          if (k == L) active = 1'b0;
        end else begin
          check("idle_tx", tx, 1);
          check("idle_busy", busy, 0);
          check("idle_done", done, 0);
          check("idle_ready", bus.in_ready, 32'(edges_since_rst >= 1));
        end
      end
    end
  end

  // Offer a word at a falling edge and wait (bounded) for it to be accepted.
  task automatic send(input logic [DW-1:0] w, input bit hold);
    exp_t e;
    int   n;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("accept_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e.data   = w;
    e.acc    = cyc;
    last_acc = cyc;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((active || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(active || sb.size() != 0), 0);
  endtask

  // Limits instance: one word, checked cycle by cycle.
  task automatic run16(input logic [15:0] w);
    int n;
    bus16.in_data  = w;
    bus16.in_valid = 1'b1;
    n = 0;
    while (bus16.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready16", bus16.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.in_data  = ~w;
    for (int k = 1; k <= L16; k++) begin
      check("tx16", tx16, 32'(exp_bit(w, DW16, CPB16, k)));
      check("busy16", busy16, 1);
      check("done16", done16, 32'(k == L16));
      @(negedge clk);
    end
    check("tx16_idle", tx16, 1);
    check("busy16_idle", busy16, 0);
    check("done16_idle", done16, 0);
    check("ready16_idle", bus16.in_ready, 1);
  endtask

  initial begin
    int acc1;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus16.in_valid = 1'b0;
    bus16.in_data  = '0;

    // Reset held with random handshake activity.
    repeat (4) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = DW'($urandom);
    end
    #2 rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("ready_before_edge", bus.in_ready, 0);
    @(negedge clk);
    check("ready_after_edge", bus.in_ready, 1);

    // Single frame.
    send(8'hA5, 1'b0);
    wait_idle();

    // Back-to-back with in_valid held; in_data changes during frame 1.
    send(8'h00, 1'b1);
    acc1 = last_acc;
    send(8'hFF, 1'b0);
    check("b2b_accept_cycle", 32'(last_acc), 32'(acc1 + L + 1));
    wait_idle();

    // A few random words with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom), 1'b0);
    end
    wait_idle();

`ifdef QUCS_SERIAL_TX_PARITY_EN
    send(8'h07, 1'b0);
    send(8'h03, 1'b0);
    wait_idle();
`endif

    // Reset during data bit 3 of 0x5A (frame cycles 17..20).
    send(8'h5A, 1'b0);
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(8'h81, 1'b0);
    wait_idle();

    // Limits: DATA_W=16, CLKS_PER_BIT=2.
    run16(16'h8001);
    run16(16'h7FFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
